// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_layer_accel_fas_vec_add_ctrl : FAS vector-add sequencer (fill, replay, per-pixel loop).
// Optional stall counter enabled by defining FAS_VEC_ADD_CTRL_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module cnn_layer_accel_fas_vec_add_ctrl #(
  parameter int C_CNT_WTH  = 16,
  parameter int C_PERF_WTH = 32
) (
  input  logic                  clk_FAS,
  input  logic                  rst,
  input  logic                  FAS_rdy_n,
  input  logic                  start,
  input  logic [2:0]            mode_cfg,
  input  logic [C_CNT_WTH-1:0]  krnl1x1_dpth_end_cfg,
  input  logic [C_CNT_WTH-1:0]  num_krnl_rpt_cfg,
  input  logic [C_CNT_WTH-1:0]  num_pix_end_cfg,
  input  logic                  krnl1x1_rdy,
  input  logic                  convMap_fifo_empty,
  input  logic                  partMap_fifo_empty,
  input  logic                  resdMap_fifo_empty,
  input  logic                  prevMap_fifo_empty,
  input  logic                  conv1x1_dwc_fifo_empty,
  output logic                  convMap_fifo_rd_en,
  output logic                  partMap_fifo_rd_en,
  output logic                  resdMap_fifo_rd_en,
  output logic                  prevMap_fifo_rd_en,
  output logic                  conv1x1_dwc_fifo_rd_en,
  output logic                  vector_add_pm,
  output logic                  vector_add_rm0,
  output logic                  vector_add_rm1,
  output logic                  vector_add_rm_conv,
  output logic                  vector_add_pv,
  output logic                  pipe_enable,
  output logic                  busy,
  output logic                  process_cmpl,
  output logic                  cfg_err,
  output logic [C_PERF_WTH-1:0] perf_stall_cnt
);

  localparam logic [2:0] MODE_PM      = 3'd0;
  localparam logic [2:0] MODE_RM0     = 3'd1;
  localparam logic [2:0] MODE_RM1     = 3'd2;
  localparam logic [2:0] MODE_RM_CONV = 3'd3;
  localparam logic [2:0] MODE_PV      = 3'd4;
  localparam logic [C_CNT_WTH-1:0] CNT_ONE  = {{(C_CNT_WTH-1){1'b0}}, 1'b1};
  localparam logic [C_CNT_WTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state;
  logic [2:0]           mode_r;
  logic [C_CNT_WTH-1:0] dpth_end_r;
  logic [C_CNT_WTH-1:0] rpt_r;
  logic [C_CNT_WTH-1:0] pix_end_r;
  logic [C_CNT_WTH-1:0] dpth_cnt;
  logic [C_CNT_WTH-1:0] krnl_cnt;
  logic [C_CNT_WTH-1:0] pix_cnt;

  // Bit order for both masks: {conv, part, resd, prev, dwc} / {pm, rm0, rm1, rm_conv, pv}
  logic [4:0] req_mask;
  logic [4:0] stb_mask;
  logic [4:0] empty_vec;

  always_comb begin
    req_mask = 5'b00000;
    stb_mask = 5'b00000;
    case (mode_r)
      MODE_PM:      begin req_mask = 5'b11000; stb_mask = 5'b10000; end
      MODE_RM0:     begin req_mask = 5'b10100; stb_mask = 5'b01000; end
      MODE_RM1:     begin req_mask = 5'b11100; stb_mask = 5'b10100; end
      MODE_RM_CONV: begin req_mask = 5'b00101; stb_mask = 5'b00010; end
      MODE_PV:      begin req_mask = 5'b00011; stb_mask = 5'b00001; end
      default:      begin req_mask = 5'b00000; stb_mask = 5'b00000; end
    endcase
  end

  assign empty_vec = {convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty,
                      prevMap_fifo_empty, conv1x1_dwc_fifo_empty};

  logic hold;
  logic mode_legal;
  logic fill_fire;
  logic rep_fire;
  logic fire;
  logic dpth_last;
  logic pass_last;
  logic pix_last;

  // Reset and abort both suppress any pop or strobe in the cycle they are seen.
  assign hold       = rst | FAS_rdy_n;
  assign mode_legal = (mode_cfg <= MODE_PV);
  assign fill_fire  = (state == ST_FILL) && !hold && krnl1x1_rdy && ((req_mask & empty_vec) == 5'b00000);
  assign rep_fire   = (state == ST_REPLAY) && !hold && krnl1x1_rdy;
  assign fire       = fill_fire | rep_fire;
  assign dpth_last  = (dpth_cnt == dpth_end_r);
  assign pass_last  = ((krnl_cnt + CNT_ONE) == rpt_r);
  assign pix_last   = (pix_cnt == pix_end_r);

  assign convMap_fifo_rd_en     = fill_fire & req_mask[4];
  assign partMap_fifo_rd_en     = fill_fire & req_mask[3];
  assign resdMap_fifo_rd_en     = fill_fire & req_mask[2];
  assign prevMap_fifo_rd_en     = fill_fire & req_mask[1];
  assign conv1x1_dwc_fifo_rd_en = fill_fire & req_mask[0];
  assign vector_add_pm          = fill_fire & stb_mask[4];
  assign vector_add_rm0         = fill_fire & stb_mask[3];
  assign vector_add_rm1         = fill_fire & stb_mask[2];
  assign vector_add_rm_conv     = fill_fire & stb_mask[1];
  assign vector_add_pv          = fill_fire & stb_mask[0];
  assign pipe_enable            = fire;

  always_ff @(posedge clk_FAS) begin
    if (rst || FAS_rdy_n) begin
      state        <= ST_IDLE;
      mode_r       <= 3'd0;
      dpth_end_r   <= CNT_ZERO;
      rpt_r        <= CNT_ZERO;
      pix_end_r    <= CNT_ZERO;
      dpth_cnt     <= CNT_ZERO;
      krnl_cnt     <= CNT_ZERO;
      pix_cnt      <= CNT_ZERO;
      busy         <= 1'b0;
      process_cmpl <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      process_cmpl <= 1'b0;
      cfg_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode_legal) begin
              mode_r     <= mode_cfg;
              dpth_end_r <= krnl1x1_dpth_end_cfg;
              rpt_r      <= num_krnl_rpt_cfg;
              pix_end_r  <= num_pix_end_cfg;
              dpth_cnt   <= CNT_ZERO;
              krnl_cnt   <= CNT_ZERO;
              pix_cnt    <= CNT_ZERO;
              busy       <= 1'b1;
              state      <= ST_FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (fill_fire) begin
            if (dpth_last) begin
              dpth_cnt <= CNT_ZERO;
              if (rpt_r != CNT_ZERO) begin
                state <= ST_REPLAY;
              end else if (pix_last) begin
                state        <= ST_DONE;
                process_cmpl <= 1'b1;
              end else begin
                pix_cnt <= pix_cnt + CNT_ONE;
              end
            end else begin
              dpth_cnt <= dpth_cnt + CNT_ONE;
            end
          end
        end
        ST_REPLAY: begin
          if (rep_fire) begin
            if (dpth_last) begin
              dpth_cnt <= CNT_ZERO;
              if (pass_last) begin
                krnl_cnt <= CNT_ZERO;
                if (pix_last) begin
                  state        <= ST_DONE;
                  process_cmpl <= 1'b1;
                end else begin
                  pix_cnt <= pix_cnt + CNT_ONE;
                  state   <= ST_FILL;
                end
              end else begin
                krnl_cnt <= krnl_cnt + CNT_ONE;
              end
            end else begin
              dpth_cnt <= dpth_cnt + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FAS_VEC_ADD_CTRL_PERF_EN
  always_ff @(posedge clk_FAS) begin
    if (rst || FAS_rdy_n) begin
      perf_stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start && mode_legal) begin
      perf_stall_cnt <= '0;
    end else if (((state == ST_FILL) || (state == ST_REPLAY)) && !fire && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
`default_nettype none
// Bench for cnn_layer_accel_fas_vec_add_ctrl: job-level beat model checked every cycle,
// plus literal per-job totals for the directed scenarios.
module tb_cnn_layer_accel_fas_vec_add_ctrl;

  logic        clk_FAS = 1'b0;
  logic        rst = 1'b1, FAS_rdy_n = 1'b0, start = 1'b0, krnl1x1_rdy = 1'b1;
  logic [2:0]  mode_cfg = 3'd0;
  logic [15:0] dpth_end_cfg = 16'd0, rpt_cfg = 16'd0, pix_end_cfg = 16'd0;
  logic        conv_e = 1'b0, part_e = 1'b0, resd_e = 1'b0, prev_e = 1'b0, dwc_e = 1'b0;
  logic        conv_rd, part_rd, resd_rd, prev_rd, dwc_rd;
  logic        s_pm, s_rm0, s_rm1, s_rmc, s_pv, pipe_enable, busy, process_cmpl, cfg_err;
  logic [31:0] perf_stall_cnt;

  always #5 clk_FAS = ~clk_FAS;

  cnn_layer_accel_fas_vec_add_ctrl #(.C_CNT_WTH(16), .C_PERF_WTH(32)) dut (
    .clk_FAS(clk_FAS), .rst(rst), .FAS_rdy_n(FAS_rdy_n), .start(start), .mode_cfg(mode_cfg),
    .krnl1x1_dpth_end_cfg(dpth_end_cfg), .num_krnl_rpt_cfg(rpt_cfg), .num_pix_end_cfg(pix_end_cfg),
    .krnl1x1_rdy(krnl1x1_rdy),
    .convMap_fifo_empty(conv_e), .partMap_fifo_empty(part_e), .resdMap_fifo_empty(resd_e),
    .prevMap_fifo_empty(prev_e), .conv1x1_dwc_fifo_empty(dwc_e),
    .convMap_fifo_rd_en(conv_rd), .partMap_fifo_rd_en(part_rd), .resdMap_fifo_rd_en(resd_rd),
    .prevMap_fifo_rd_en(prev_rd), .conv1x1_dwc_fifo_rd_en(dwc_rd),
    .vector_add_pm(s_pm), .vector_add_rm0(s_rm0), .vector_add_rm1(s_rm1),
    .vector_add_rm_conv(s_rmc), .vector_add_pv(s_pv), .pipe_enable(pipe_enable),
    .busy(busy), .process_cmpl(process_cmpl), .cfg_err(cfg_err), .perf_stall_cnt(perf_stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Required FIFOs {conv,part,resd,prev,dwc} and strobes {pm,rm0,rm1,rm_conv,pv} per mode.
  function automatic logic [4:0] req_of(input int m);
    case (m)
      0: return 5'b11000;  1: return 5'b10100;  2: return 5'b11100;
      3: return 5'b00101;  4: return 5'b00011;  default: return 5'b00000;
    endcase
  endfunction
  function automatic logic [4:0] stb_of(input int m);
    case (m)
      0: return 5'b10000;  1: return 5'b01000;  2: return 5'b10100;
      3: return 5'b00010;  4: return 5'b00001;  default: return 5'b00000;
    endcase
  endfunction

  // Job model: a job is a flat list of beats; beat k is a fill beat when it falls
  // within the first (end+1) beats of its pixel's group of (end+1)*(1+rpt) beats.
  bit m_valid = 0, m_active = 0, m_done = 0, m_cfgerr = 0;
  int m_mode, m_fill, m_rpt, m_total, m_k, m_stall;
  int pe_tot = 0, cmpl_tot = 0, err_tot = 0;
  int pop_tot [5] = '{0, 0, 0, 0, 0};

  always @(negedge clk_FAS) begin : compare
    logic [4:0]  emp, e_rd, e_stb;
    logic        e_pe;
    logic [13:0] act_v, exp_v;
    int          j;
    emp  = {conv_e, part_e, resd_e, prev_e, dwc_e};
    e_rd = '0; e_stb = '0; e_pe = 1'b0;
    if (m_active && !rst && !FAS_rdy_n && krnl1x1_rdy) begin
      j = m_k % (m_fill * (1 + m_rpt));
      if (j >= m_fill) e_pe = 1'b1;
      else if ((req_of(m_mode) & emp) == 5'b00000) begin
        e_pe = 1'b1; e_rd = req_of(m_mode); e_stb = stb_of(m_mode);
      end
    end
    act_v = {conv_rd, part_rd, resd_rd, prev_rd, dwc_rd, s_pm, s_rm0, s_rm1, s_rmc, s_pv,
             pipe_enable, busy, process_cmpl, cfg_err};
    exp_v = {e_rd, e_stb, e_pe, m_active | m_done, m_done, m_cfgerr};
    if (m_valid) begin
      chk("cycle_outputs", act_v, exp_v);
`ifdef FAS_VEC_ADD_CTRL_PERF_EN
      chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`else
      chk("perf_stall_cnt", perf_stall_cnt, 0);
`endif
    end
    pe_tot += int'(pipe_enable); cmpl_tot += int'(process_cmpl); err_tot += int'(cfg_err);
    pop_tot[0] += int'(conv_rd); pop_tot[1] += int'(part_rd); pop_tot[2] += int'(resd_rd);
    pop_tot[3] += int'(prev_rd); pop_tot[4] += int'(dwc_rd);
    // Advance the model to what the next rising edge will produce.
    if (rst || FAS_rdy_n) begin
      m_valid = 1; m_active = 0; m_done = 0; m_cfgerr = 0; m_stall = 0;
    end else begin
      m_cfgerr = (!m_active && !m_done && start && mode_cfg > 3'd4);
      if (m_done) m_done = 0;
      else if (m_active) begin
        if (e_pe) begin
          m_k++;
          if (m_k == m_total) begin m_active = 0; m_done = 1; end
        end else m_stall++;
      end else if (start && mode_cfg <= 3'd4) begin
        m_mode = int'(mode_cfg); m_fill = int'(dpth_end_cfg) + 1; m_rpt = int'(rpt_cfg);
        m_total = m_fill * (1 + m_rpt) * (int'(pix_end_cfg) + 1);
        m_k = 0; m_stall = 0; m_active = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_FAS); #1;
  endtask

  task automatic kick(input logic [2:0] m, input int de, input int rp, input int pe);
    mode_cfg = m; dpth_end_cfg = 16'(de); rpt_cfg = 16'(rp); pix_end_cfg = 16'(pe);
    start = 1'b1; tick(); start = 1'b0;
    mode_cfg = 3'd7; dpth_end_cfg = 16'hFFFF; rpt_cfg = 16'hFFFF; pix_end_cfg = 16'hFFFF;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 500 && busy; i++) tick();
    chk("wait_idle_timeout", busy, 0);
    tick();
  endtask

  int pe0, cm0, er0;
  int p0 [5];

  task automatic snap();
    pe0 = pe_tot; cm0 = cmpl_tot; er0 = err_tot;
    for (int i = 0; i < 5; i++) p0[i] = pop_tot[i];
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_perf", perf_stall_cnt, 0);

    // 1: PM, 4 beats, one pixel, no replay
    snap(); kick(3'd0, 3, 0, 0); wait_idle();
    chk("t1_pipe_en", pe_tot - pe0, 4);
    chk("t1_conv_pops", pop_tot[0] - p0[0], 4);
    chk("t1_part_pops", pop_tot[1] - p0[1], 4);
    chk("t1_cmpl", cmpl_tot - cm0, 1);

    // 2: RM1, 2 fill + 4 replay beats per pixel, two pixels
    snap(); kick(3'd2, 1, 2, 1); wait_idle();
    chk("t2_pipe_en", pe_tot - pe0, 12);
    chk("t2_conv_pops", pop_tot[0] - p0[0], 4);
    chk("t2_part_pops", pop_tot[1] - p0[1], 4);
    chk("t2_resd_pops", pop_tot[2] - p0[2], 4);

    // 3: PV with unrelated FIFOs empty and a 3-cycle prev gap after two beats
    part_e = 1'b1; resd_e = 1'b1;
    snap(); kick(3'd4, 3, 0, 0);
    tick(); tick();
    prev_e = 1'b1; repeat (3) tick(); prev_e = 1'b0;
    wait_idle();
    chk("t3_pipe_en", pe_tot - pe0, 4);
    chk("t3_prev_pops", pop_tot[3] - p0[3], 4);
    chk("t3_dwc_pops", pop_tot[4] - p0[4], 4);
`ifdef FAS_VEC_ADD_CTRL_PERF_EN
    chk("t3_perf", perf_stall_cnt, 3);
`else
    chk("t3_perf", perf_stall_cnt, 0);
`endif
    part_e = 1'b0; resd_e = 1'b0;

    // 4: RM0, downstream not ready for 5 cycles during replay
    snap(); kick(3'd1, 1, 2, 0);
    tick(); tick();
    krnl1x1_rdy = 1'b0; repeat (5) tick(); krnl1x1_rdy = 1'b1;
    wait_idle();
    chk("t4_pipe_en", pe_tot - pe0, 6);
`ifdef FAS_VEC_ADD_CTRL_PERF_EN
    chk("t4_perf", perf_stall_cnt, 5);
`else
    chk("t4_perf", perf_stall_cnt, 0);
`endif

    // 5: illegal mode, then start while busy is ignored
    snap(); kick(3'd6, 3, 0, 0); tick();
    chk("t5_cfg_err", err_tot - er0, 1);
    chk("t5_idle", busy, 0);
    snap(); kick(3'd3, 2, 0, 0);
    kick(3'd6, 9, 9, 9);
    wait_idle();
    chk("t5_pipe_en", pe_tot - pe0, 3);
    chk("t5_no_err_busy", err_tot - er0, 0);

    // 6: abort mid-fill, then a clean job
    kick(3'd0, 7, 0, 0);
    tick(); tick();
    FAS_rdy_n = 1'b1; tick(); FAS_rdy_n = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_perf", perf_stall_cnt, 0);
    snap(); kick(3'd0, 7, 0, 0); wait_idle();
    chk("t6_pipe_en", pe_tot - pe0, 8);
    chk("t6_cmpl", cmpl_tot - cm0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
